// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_AWIDTH    = 14;
  localparam int unsigned BE_WIDTH       = 4;
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  // Which requester, if any, has a read in flight whose data returns next cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arb_grant.sv
// Fixed-priority grant with a forced DMA grant once the DMA has waited MAX_WAIT cycles.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                      cpu_req,
  input  logic                      dma_req,
  input  logic [WAIT_CNT_WIDTH-1:0] wait_cnt,
  output logic                      cpu_gnt,
  output logic                      dma_gnt
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic force_gnt;

  // CPU wins unless the DMA has been starved long enough to be forced through.
  always_comb begin
    force_gnt = dma_req && (wait_cnt == MAX_WAIT_C);
    dma_gnt   = dma_req && (!cpu_req || force_gnt);
    cpu_gnt   = cpu_req && !dma_gnt;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU load/store path and the DMA engine,
// tracking read ownership so data returns to the issuer one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH   = DMEM_AWIDTH,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [AWIDTH-1:0]   cpu_addr,
  input  logic [BE_WIDTH-1:0] cpu_we,
  input  logic [DWIDTH-1:0]   cpu_wdata,
  output logic                cpu_stall,
  output logic                cpu_rvalid,
  output logic [DWIDTH-1:0]   cpu_rdata,
  input  logic                dma_req,
  input  logic [AWIDTH-1:0]   dma_addr,
  input  logic [BE_WIDTH-1:0] dma_we,
  input  logic [DWIDTH-1:0]   dma_wdata,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DWIDTH-1:0]   dma_rdata,
  output logic                mem_en,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [BE_WIDTH-1:0] mem_we,
  output logic [DWIDTH-1:0]   mem_din,
  input  logic [DWIDTH-1:0]   mem_dout
);

  rd_owner_e                 rd_owner_q, rd_owner_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                      cpu_req_eff, dma_req_eff;
  logic                      cpu_gnt;

  // Requests are masked while reset is held so every output stays quiet.
  always_comb begin
    cpu_req_eff = cpu_req && !rst;
    dma_req_eff = dma_req && !rst;
  end

  dmem_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .cpu_req  (cpu_req_eff),
    .dma_req  (dma_req_eff),
    .wait_cnt (wait_cnt_q),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt)
  );

  // Drive the memory port from whichever requester was granted.
  always_comb begin
    cpu_stall = cpu_req_eff && !cpu_gnt;
    mem_en    = cpu_gnt || dma_gnt;
    mem_addr  = '0;
    mem_we    = '0;
    mem_din   = '0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_din  = cpu_wdata;
    end else if (dma_gnt) begin
      mem_addr = dma_addr;
      mem_we   = dma_we;
      mem_din  = dma_wdata;
    end
  end

  // Count consecutive cycles the DMA has been denied; any grant or idle cycle clears it.
  always_comb begin
    wait_cnt_d = '0;
    if (dma_req_eff && !dma_gnt) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read-owner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q <= IDLE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // A granted read claims next cycle's return slot; writes and idle cycles release it.
  always_comb begin
    rd_owner_d = IDLE;
    if (cpu_gnt && (cpu_we == '0)) begin
      rd_owner_d = CPU_RD;
    end else if (dma_gnt && (dma_we == '0)) begin
      rd_owner_d = DMA_RD;
    end
  end

  // Route the returning memory data to the owner of the previous cycle's read.
  always_comb begin
    cpu_rvalid = (rd_owner_q == CPU_RD);
    dma_rvalid = (rd_owner_q == DMA_RD);
    cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    dma_rdata  = dma_rvalid ? mem_dout : '0;
  end

endmodule
